// File: rtl/cf_ss_422to444_p_pkg.sv
// Shared constants for the 4:2:2 -> 4:4:4 chroma upsampler: pipeline latency,
// packed-bus field positions and the midscale value used for absent chroma.
package cf_ss_pkg;

    localparam int LAT = 4;

    // Field positions, in units of one DW-wide component, inside the packed buses.
    localparam int IN_Y_FIELD   = 0;
    localparam int IN_C_FIELD   = 1;
    localparam int OUT_CB_FIELD = 0;
    localparam int OUT_Y_FIELD  = 1;
    localparam int OUT_CR_FIELD = 2;

    function automatic int midscale(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/cf_ss_422to444_p_tap3.sv
// 1-2-1 rounding filter for one chroma component; edge flags fold the missing
// neighbour onto the centre tap, bypass passes the held sample straight through.
module cf_ss_tap3 #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] c_prev,
    input  logic [DW-1:0] c_cur,
    input  logic [DW-1:0] c_next,
    input  logic          first,
    input  logic          last,
    input  logic          bypass,
    output logic [DW-1:0] c_out
);

    logic [DW-1:0] tap_p;
    logic [DW-1:0] tap_n;
    logic [DW+1:0] sum;

    // Worst case 4*(2^DW-1)+2 still fits in DW+2 bits.
    always_comb begin
        tap_p = first ? c_cur : c_prev;
        tap_n = last ? c_cur : c_next;
        sum   = {2'b00, tap_p} + {1'b0, c_cur, 1'b0} + {2'b00, tap_n} + (DW+2)'(2);
        c_out = bypass ? c_cur : sum[DW+1:2];
    end

endmodule

// File: rtl/cf_ss_422to444_p.sv
// 4:2:2 -> 4:4:4 chroma upsampler with fixed 4-cycle latency. s422_de qualifies each
// pixel and there is no ready: a pixel is taken on every rising edge with s422_de=1.
module cf_ss_422to444_p
    import cf_ss_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s422_vs,
    input  logic              s422_hs,
    input  logic              s422_de,
    input  logic [2*DW-1:0]   s422_data,
    input  logic              Cr_Cb_sel_init,
    input  logic              mode,
    output logic              s444_vs,
    output logic              s444_hs,
    output logic              s444_de,
    output logic [3*DW-1:0]   s444_data
);

    localparam logic [DW-1:0] MID = DW'(midscale(DW));

    logic [DW-1:0] in_c;
    logic [DW-1:0] in_y;
    logic [2:0]    sync_q [LAT];
    logic          flag;
    logic          mode_q;

    logic          s1_de, s1_cr, s1_mode;
    logic [DW-1:0] s1_c, s1_y;
    logic [DW-1:0] h_cr, h_cb;
    logic          hv_cr, hv_cb;
    logic          nxt_valid;
    logic [DW-1:0] cr_hold, cb_hold;

    logic          p2_de, p2_mode, p3_de, p3_mode, p4_de;
    logic [DW-1:0] p2_cr, p2_cb, p2_y, p3_cr, p3_cb, p3_y, p4_cr, p4_cb;
    logic [DW-1:0] filt_cr, filt_cb;
    logic [3*DW-1:0] out_data;

    assign in_c = s422_data[IN_C_FIELD*DW +: DW];
    assign in_y = s422_data[IN_Y_FIELD*DW +: DW];

    // Held chroma for the pixel in s1. Only the first pixel of a line can lack an
    // earlier sample of a component; it borrows the next pixel's sample if in-line.
    always_comb begin
        nxt_valid = s422_de & s1_de;
        cr_hold   = MID;
        cb_hold   = MID;
        if (s1_cr)                  cr_hold = s1_c;
        else if (hv_cr)             cr_hold = h_cr;
        else if (nxt_valid && flag) cr_hold = in_c;
        if (!s1_cr)                  cb_hold = s1_c;
        else if (hv_cb)              cb_hold = h_cb;
        else if (nxt_valid && !flag) cb_hold = in_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
            flag     <= Cr_Cb_sel_init;
            mode_q   <= mode;
            s1_de    <= 1'b0;
            s1_cr    <= 1'b0;
            s1_mode  <= 1'b0;
            s1_c     <= '0;
            s1_y     <= '0;
            h_cr     <= '0;
            h_cb     <= '0;
            hv_cr    <= 1'b0;
            hv_cb    <= 1'b0;
            p2_de    <= 1'b0;
            p2_mode  <= 1'b0;
            p2_cr    <= '0;
            p2_cb    <= '0;
            p2_y     <= '0;
            p3_de    <= 1'b0;
            p3_mode  <= 1'b0;
            p3_cr    <= '0;
            p3_cb    <= '0;
            p3_y     <= '0;
            p4_de    <= 1'b0;
            p4_cr    <= '0;
            p4_cb    <= '0;
            out_data <= '0;
        end else begin
            sync_q[0] <= {s422_vs, s422_hs, s422_de};
            for (int i = 1; i < LAT; i++) sync_q[i] <= sync_q[i-1];
            flag <= s422_de ? ~flag : Cr_Cb_sel_init;
            if (!s422_de) mode_q <= mode;

            s1_de   <= s422_de;
            s1_cr   <= flag;
            s1_mode <= mode_q;
            s1_c    <= in_c;
            s1_y    <= in_y;

            // Latest sample of each component seen so far in the current line.
            if (s1_de) begin
                if (s1_cr) begin
                    h_cr  <= s1_c;
                    hv_cr <= 1'b1;
                end else begin
                    h_cb  <= s1_c;
                    hv_cb <= 1'b1;
                end
            end else begin
                hv_cr <= 1'b0;
                hv_cb <= 1'b0;
            end

            p2_de   <= s1_de;
            p2_mode <= s1_mode;
            p2_cr   <= cr_hold;
            p2_cb   <= cb_hold;
            p2_y    <= s1_y;
            p3_de   <= p2_de;
            p3_mode <= p2_mode;
            p3_cr   <= p2_cr;
            p3_cb   <= p2_cb;
            p3_y    <= p2_y;
            p4_de   <= p3_de;
            p4_cr   <= p3_cr;
            p4_cb   <= p3_cb;

            out_data <= '0;
            if (p3_de) begin
                out_data[OUT_CR_FIELD*DW +: DW] <= filt_cr;
                out_data[OUT_Y_FIELD*DW +: DW]  <= p3_y;
                out_data[OUT_CB_FIELD*DW +: DW] <= filt_cb;
            end
        end
    end

    // p4/p3/p2 hold pixels n-1/n/n+1; a de=0 neighbour marks a line edge.
    cf_ss_tap3 #(.DW(DW)) u_tap_cr (
        .c_prev (p4_cr),
        .c_cur  (p3_cr),
        .c_next (p2_cr),
        .first  (~p4_de),
        .last   (~p2_de),
        .bypass (p3_mode),
        .c_out  (filt_cr)
    );

    cf_ss_tap3 #(.DW(DW)) u_tap_cb (
        .c_prev (p4_cb),
        .c_cur  (p3_cb),
        .c_next (p2_cb),
        .first  (~p4_de),
        .last   (~p2_de),
        .bypass (p3_mode),
        .c_out  (filt_cb)
    );

    assign s444_vs   = sync_q[LAT-1][2] & ~rst;
    assign s444_hs   = sync_q[LAT-1][1] & ~rst;
    assign s444_de   = sync_q[LAT-1][0] & ~rst;
    assign s444_data = rst ? '0 : out_data;

endmodule

// File: tb/tb_cf_ss_422to444_p.sv
// Randomised and directed bench for cf_ss_422to444_p at DW=8 and DW=10, checked
// per cycle against a line-level reference model through expected-value queues.
module tb_cf_ss_422to444_p;
    import cf_ss_pkg::*;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, vs = 1'b0, hs = 1'b0, de = 1'b0, init = 1'b0, mode = 1'b0;
    logic [15:0] data = '0;
    logic [19:0] data10 = '1;
    logic        o_vs, o_hs, o_de, t_vs, t_hs, t_de;
    logic [23:0] o_data;
    logic [29:0] t_data;

    cf_ss_422to444_p #(.DW(8)) dut (
        .clk(clk), .rst(rst), .s422_vs(vs), .s422_hs(hs), .s422_de(de),
        .s422_data(data), .Cr_Cb_sel_init(init), .mode(mode),
        .s444_vs(o_vs), .s444_hs(o_hs), .s444_de(o_de), .s444_data(o_data)
    );

    cf_ss_422to444_p #(.DW(10)) dut10 (
        .clk(clk), .rst(rst), .s422_vs(vs), .s422_hs(hs), .s422_de(de),
        .s422_data(data10), .Cr_Cb_sel_init(init), .mode(mode),
        .s444_vs(t_vs), .s444_hs(t_hs), .s444_de(t_de), .s444_data(t_data)
    );

    bit   st_rst[MAXC], st_vs[MAXC], st_hs[MAXC], st_de[MAXC], st_init[MAXC], st_mode[MAXC];
    int   st_c[MAXC], st_y[MAXC];
    int   n_cyc = 0;
    logic [2:0] m_sync[MAXC];
    int   m_cr[MAXC], m_y[MAXC], m_cb[MAXC];
    logic [26:0] exp8[MAXC];
    logic [32:0] exp10[MAXC];
    logic [26:0] exp_q[$];
    logic [32:0] exp10_q[$];
    logic [23:0] dir_exp[int];
    int   n_cmp = 0, n_fail = 0;

    function automatic logic [23:0] pk(input int cr, input int y, input int cb);
        return {8'(cr), 8'(y), 8'(cb)};
    endfunction

    function automatic bit eff(input int k);
        return st_de[k] && !st_rst[k];
    endfunction

    task automatic push_cyc(input bit r, input bit v, input bit h, input bit d,
                            input int c, input int y, input bit ini, input bit md);
        if (n_cyc < MAXC) begin
            st_rst[n_cyc] = r; st_vs[n_cyc] = v; st_hs[n_cyc] = h; st_de[n_cyc] = d;
            st_c[n_cyc] = c; st_y[n_cyc] = y; st_init[n_cyc] = ini; st_mode[n_cyc] = md;
            n_cyc++;
        end
    endtask

    task automatic gap(input int n, input bit ini, input bit md);
        for (int i = 0; i < n; i++) push_cyc(0, 0, 0, 0, 0, 0, ini, md);
    endtask

    // One line: held values by the "latest, else first in line, else midscale" rule.
    task automatic line_out(input int dw, input bit ones, input int s, input int ln);
        int hcr[], hcb[];
        int mx, mid, cur_cr, cur_cb, ch, p, n;
        bit ini, md, is_cr;
        mx = (1 << dw) - 1;
        mid = 1 << (dw - 1);
        ini = st_init[s-1];
        md = st_mode[s-1];
        hcr = new[ln];
        hcb = new[ln];
        cur_cr = mid;
        cur_cb = mid;
        for (int i = ln - 1; i >= 0; i--) begin
            ch = ones ? mx : st_c[s+i];
            if (ini ^ i[0]) cur_cr = ch; else cur_cb = ch;
        end
        for (int i = 0; i < ln; i++) begin
            ch = ones ? mx : st_c[s+i];
            is_cr = ini ^ i[0];
            if (is_cr) cur_cr = ch; else cur_cb = ch;
            hcr[i] = cur_cr;
            hcb[i] = cur_cb;
        end
        for (int i = 0; i < ln; i++) begin
            if (s + i + LAT < n_cyc) begin
                p = (i == 0) ? i : i - 1;
                n = (i == ln - 1) ? i : i + 1;
                m_cr[s+i+LAT] = md ? hcr[i] : (hcr[p] + 2 * hcr[i] + hcr[n] + 2) / 4;
                m_cb[s+i+LAT] = md ? hcb[i] : (hcb[p] + 2 * hcb[i] + hcb[n] + 2) / 4;
                m_y[s+i+LAT]  = ones ? mx : st_y[s+i];
            end
        end
    endtask

    task automatic run_model(input int dw, input bit ones);
        int k, s;
        bit kill;
        for (int i = 0; i < n_cyc; i++) begin
            m_sync[i] = '0; m_cr[i] = 0; m_y[i] = 0; m_cb[i] = 0;
        end
        k = 0;
        while (k < n_cyc) begin
            if (!eff(k)) k++;
            else begin
                s = k;
                while (k < n_cyc && eff(k)) k++;
                line_out(dw, ones, s, k - s);
            end
        end
        // Any reset between a pixel's entry and its output slot wipes that slot.
        for (int i = 0; i < n_cyc; i++) begin
            kill = (i < LAT);
            if (!kill) begin
                for (int j = i - LAT; j <= i; j++) if (st_rst[j]) kill = 1;
            end
            if (kill) begin
                m_sync[i] = '0; m_cr[i] = 0; m_y[i] = 0; m_cb[i] = 0;
            end else begin
                m_sync[i] = {st_vs[i-LAT], st_hs[i-LAT], st_de[i-LAT]};
                if (!st_de[i-LAT]) begin m_cr[i] = 0; m_y[i] = 0; m_cb[i] = 0; end
            end
        end
    endtask

    task automatic build_stim();
        int s, r, g, ln;
        bit md;
        for (int i = 0; i < 4; i++) push_cyc(1, 0, 0, 0, 0, 0, 0, 0);
        gap(3, 0, 1);
        s = n_cyc;
        for (int i = 0; i < 4; i++) push_cyc(0, 0, 0, 1, 10 * (i + 1), i + 1, 0, 1);
        dir_exp[s+4] = pk(20, 1, 10); dir_exp[s+5] = pk(20, 2, 10);
        dir_exp[s+6] = pk(20, 3, 30); dir_exp[s+7] = pk(40, 4, 30);
        gap(3, 0, 0);
        s = n_cyc;
        for (int i = 0; i < 4; i++) push_cyc(0, 0, 0, 1, 10 * (i + 1), i + 1, 0, 0);
        dir_exp[s+4] = pk(20, 1, 10); dir_exp[s+5] = pk(20, 2, 15);
        dir_exp[s+6] = pk(25, 3, 25); dir_exp[s+7] = pk(35, 4, 30);
        gap(2, 1, 0);
        s = n_cyc;
        push_cyc(0, 0, 0, 1, 200, 50, 1, 0);
        dir_exp[s+4] = pk(200, 50, 128); dir_exp[s+5] = 24'h0;
        for (int m = 0; m < 2; m++) begin
            gap(2, m[0], m[0]);
            s = n_cyc;
            for (int i = 0; i < 5; i++) push_cyc(0, 0, 0, 1, 255, 255, m[0], m[0]);
            for (int i = 0; i < 5; i++) dir_exp[s+4+i] = pk(255, 255, 255);
        end
        gap(2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) r = n_cyc;
            push_cyc(i == 2, 0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
        end
        for (int j = 0; j <= LAT; j++) dir_exp[r+j] = 24'h0;
        gap(1, 1, 0);
        for (int i = 0; i < 6; i++) push_cyc(0, 0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 1, 0);
        for (int l = 0; l < 120; l++) begin
            md = 1'($urandom_range(0, 1));
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
            for (int i = 0; i < g; i++)
                push_cyc(0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 0,
                         $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), md);
            ln = $urandom_range(1, 12);
            for (int i = 0; i < ln; i++)
                push_cyc(0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1,
                         $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), md);
        end
        gap(8, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic [26:0] got8, e8;
        logic [32:0] got10, e10;
        build_stim();
        run_model(8, 0);
        for (int i = 0; i < n_cyc; i++) exp8[i] = {m_sync[i], 8'(m_cr[i]), 8'(m_y[i]), 8'(m_cb[i])};
        run_model(10, 1);
        for (int i = 0; i < n_cyc; i++) exp10[i] = {m_sync[i], 10'(m_cr[i]), 10'(m_y[i]), 10'(m_cb[i])};
        for (int i = 0; i < LAT; i++) begin
            exp_q.push_back(exp8[i]);
            exp10_q.push_back(exp10[i]);
        end
        fork
            begin : driver
                for (int c = 0; c < n_cyc; c++) begin
                    @(posedge clk);
                    #1;
                    rst = st_rst[c]; vs = st_vs[c]; hs = st_hs[c]; de = st_de[c];
                    init = st_init[c]; mode = st_mode[c];
                    data = {8'(st_c[c]), 8'(st_y[c])};
                    if (c + LAT < n_cyc) begin
                        exp_q.push_back(exp8[c+LAT]);
                        exp10_q.push_back(exp10[c+LAT]);
                    end
                end
            end
            begin : monitor
                for (int c = 0; c < n_cyc; c++) begin
                    @(negedge clk);
                    got8 = {o_vs, o_hs, o_de, o_data};
                    got10 = {t_vs, t_hs, t_de, t_data};
                    n_cmp += 2;
                    if (exp_q.size() == 0 || exp10_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL queue_underflow cyc %0d got %h / %h required an expected entry", c, got8, got10);
                    end else begin
                        e8 = exp_q.pop_front();
                        e10 = exp10_q.pop_front();
                        if (got8 !== e8) begin
                            n_fail++;
                            $display("FAIL out_dw8 cyc %0d got %h required %h", c, got8, e8);
                        end
                        if (got10 !== e10) begin
                            n_fail++;
                            $display("FAIL out_dw10 cyc %0d got %h required %h", c, got10, e10);
                        end
                    end
                    if (dir_exp.exists(c)) begin
                        n_cmp++;
                        if (o_data !== dir_exp[c]) begin
                            n_fail++;
                            $display("FAIL directed_data cyc %0d got %h required %h", c, o_data, dir_exp[c]);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_leftover got %0d entries required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cf_ss_422to444_p.md
CF_SS_422TO444_P -- requirements
Module: cf_ss_422to444_p

Interface
REQ-001 Parameter DW, default 8, legal 8..12: bits per video component.
REQ-002 Parameter LAT, fixed 4: input-to-output latency in clk cycles, not overridable.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s422_vs / s422_hs / s422_de  input  1 each  input syncs and data enable.
REQ-006 s422_data  input  2*DW  {chroma[2*DW-1:DW], luma Y[DW-1:0]}.
REQ-007 Cr_Cb_sel_init  input  1  chroma phase of the first pixel of a line: 1 = Cr, 0 = Cb.
REQ-008 mode  input  1  0 = 1-2-1 interpolate, 1 = sample-hold replicate; sampled only when s422_de=0, held constant across a line.
REQ-009 s444_vs / s444_hs / s444_de  output  1 each  syncs and enable delayed by LAT.
REQ-010 s444_data  output  3*DW  {Cr, Y, Cb}.

Function
REQ-011 A line SHALL be a maximal run of consecutive cycles with s422_de=1; any de=0 cycle ends it.
REQ-012 The phase flag SHALL reload Cr_Cb_sel_init on every de=0 cycle and toggle on every de=1 cycle; pixel n of a line carries Cr when flag=1, else Cb.
REQ-013 Held Crh[n]/Cbh[n] SHALL be the latest Cr/Cb received at or before pixel n; before the first sample of that component in the line, the line's first sample of it (one-pixel look-ahead backfill) is used.
REQ-014 A component with no sample in the line SHALL be held at midscale 2^(DW-1).
REQ-015 Replicate mode: output Cr[n]=Crh[n], Cb[n]=Cbh[n].
REQ-016 Interpolate mode: output C[n]=(Ch[n-1]+2*Ch[n]+Ch[n+1]+2)>>2, computed in DW+2 bits and truncated to DW; this never overflows.
REQ-017 Edge rule: at the first pixel Ch[n-1]=Ch[n]; at the last pixel Ch[n+1]=Ch[n]; a one-pixel line uses Ch[n] for all taps.
REQ-018 Output Y[n] SHALL equal input luma of pixel n unchanged.
REQ-019 s444_vs/hs/de SHALL equal the inputs delayed exactly LAT cycles, with no dependence on de.
REQ-020 s444_data SHALL be all-zero on every cycle where s444_de=0.
REQ-021 The block SHALL accept a new pixel every cycle (no backpressure); back-to-back lines separated by one de=0 cycle SHALL be processed independently.

Reset
REQ-022 While rst=1: all outputs 0, all pipeline stages cleared (de stages 0), phase flag loads Cr_Cb_sel_init.
REQ-023 Reset mid-line SHALL discard that line; outputs SHALL stay 0 for LAT cycles after rst deasserts; a line starting after deassert SHALL be processed normally.

Structure
REQ-024 Package cf_ss_pkg SHALL hold the LAT constant, the component field-order localparams and a midscale function of DW.
REQ-025 One sub-module cf_ss_tap3 (DW-parameterised 1-2-1 rounding filter with first/last edge-select inputs and a bypass for replicate mode) SHALL be instantiated once per chroma component.

Verification (DW=8 unless noted; chroma/luma as {C,Y})
REQ-026 Replicate, init=0, line {10,1},{20,2},{30,3},{40,4} -> cycles 4..7 output {Cr,Y,Cb} = {20,1,10},{20,2,10},{20,3,30},{40,4,30}.
REQ-027 Interpolate, same stimulus -> {20,1,10},{20,2,15},{25,3,25},{35,4,30}.
REQ-028 Interpolate, init=1, single pixel {200,50} -> one output {200,50,128}, then zero data.
REQ-029 Full-scale line of all 255 in both modes -> all components 255; DW=10 with all 1023 -> 1023.
REQ-030 rst pulsed one cycle at pixel 2 of an 8-pixel line -> outputs 0 during rst and the next 4 cycles; the following line matches the reference model.
REQ-031 Random vs/hs/de with one-cycle gaps between lines -> syncs delayed exactly 4, data zero whenever s444_de=0, scoreboard match.
